// File: rtl/clkdiv_pkg.sv
// Shared constants and types for the multi-channel clock divider.
package clkdiv_pkg;

  localparam int unsigned DEF_CNT_W = 18;
  localparam int unsigned DEF_HALF  = 250000;

  // Per-channel state at the default counter width.
  typedef struct packed {
    logic [DEF_CNT_W-1:0] cnt;
    logic [DEF_CNT_W-1:0] half;
    logic [DEF_CNT_W-1:0] pend_val;
    logic                 pend;
  } chan_state_t;

  // Channel index width, never narrower than one bit.
  function automatic int unsigned ch_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clock_divider_chan.sv
// One divider channel: counter, pending half-period register and terminal-count logic.
module clock_divider_chan
  import clkdiv_pkg::*;
#(
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned RST_HALF = DEF_HALF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             sync,
  input  logic             acc,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             pend,
  output logic             clk_out,
  output logic             tick
);

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] pend_val;
    logic             pend;
  } state_t;

  state_t q;
  state_t d;
  logic   clk_d;
  logic   tick_d;
  logic   parked;
  logic   tc;

  assign parked = (q.half == '0);
  assign tc     = !parked && (q.cnt == q.half - CNT_W'(1));
  assign pend   = q.pend;

  // Next state: idle (disabled/synced/parked) beats TC, TC beats counting.
  always_comb begin
    d      = q;
    clk_d  = clk_out;
    tick_d = 1'b0;
    if (!en || sync || parked) begin
      d.cnt = '0;
      clk_d = 1'b0;
      if (q.pend) begin
        d.half = q.pend_val;
        d.pend = 1'b0;
      end
    end else if (tc) begin
      d.cnt  = '0;
      clk_d  = !clk_out;
      tick_d = 1'b1;
      if (q.pend) begin
        d.half = q.pend_val;
        d.pend = 1'b0;
      end
    end else begin
      d.cnt = q.cnt + CNT_W'(1);
    end
    // Accept only happens while pend is clear, so it never collides with an apply.
    if (acc) begin
      d.pend_val = cfg_half;
      d.pend     = 1'b1;
    end
  end

  // Channel state and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q       <= '{cnt: '0, half: CNT_W'(RST_HALF), pend_val: '0, pend: 1'b0};
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      q       <= d;
      clk_out <= clk_d;
      tick    <= tick_d;
    end
  end

endmodule

// File: rtl/clock_divider_multi.sv
// NUM_CH independent run-time programmable clock dividers with shared config port and sync.
module clock_divider_multi
  import clkdiv_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned DEF_HALF = clkdiv_pkg::DEF_HALF,
  parameter int unsigned CH_W     = ch_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_chan,
  input  logic [CNT_W-1:0]  cfg_half,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] acc;

  // Ready mux; out-of-range channels are always ready and the write is dropped.
  always_comb begin
    cfg_ready = 1'b1;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (cfg_chan == CH_W'(i)) cfg_ready = !pend[i];
    end
  end

  // Per-channel accept decode.
  always_comb begin
    acc = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      acc[i] = cfg_valid && cfg_ready && (cfg_chan == CH_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    clock_divider_chan #(
      .CNT_W    (CNT_W),
      .RST_HALF (DEF_HALF)
    ) u_chan (
      .clk      (clk),
      .reset_n  (reset_n),
      .en       (en[g]),
      .sync     (sync),
      .acc      (acc[g]),
      .cfg_half (cfg_half),
      .pend     (pend[g]),
      .clk_out  (clk_out[g]),
      .tick     (tick[g])
    );
  end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Scoreboard bench for clock_divider_multi with NUM_CH=2, DEF_HALF=3.
module tb_clock_divider_multi;

  localparam int unsigned NCH  = 2;
  localparam int unsigned CW   = 8;
  localparam int unsigned DH   = 3;

  logic           clk;
  logic           reset_n;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [0:0]     cfg_chan;
  logic [CW-1:0]  cfg_half;
  logic [NCH-1:0] en;
  logic           sync;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] tick;

  int tests_run = 0;
  int failures  = 0;

  // Reference model state
  int m_cnt  [NCH];
  int m_half [NCH];
  int m_pval [NCH];
  bit m_pend [NCH];
  bit m_clk  [NCH];
  bit m_tick [NCH];
  logic [3:0] exp_q [$];
  logic [3:0] exp_v;

  clock_divider_multi #(
    .NUM_CH   (NCH),
    .CNT_W    (CW),
    .DEF_HALF (DH),
    .CH_W     (1)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_chan  (cfg_chan),
    .cfg_half  (cfg_half),
    .en        (en),
    .sync      (sync),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  // Scoreboard: pop the expected outputs for each edge and compare.
  always @(posedge clk) begin
    #1;
    if (reset_n && exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      tests_run++;
      if ({clk_out, tick} !== exp_v) begin
        failures++;
        $display("FAIL scoreboard t=%0t {clk_out,tick} got=%b exp=%b", $time, {clk_out, tick}, exp_v);
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_cnt[i] = 0; m_half[i] = DH; m_pval[i] = 0;
      m_pend[i] = 0; m_clk[i] = 0; m_tick[i] = 0;
    end
    exp_q.delete();
  endtask

  // Advance the model by one clock with the current inputs and queue the expected outputs.
  task automatic cyc();
    bit acc [NCH];
    #1;
    for (int i = 0; i < NCH; i++)
      acc[i] = cfg_valid && (int'(cfg_chan) == i) && !m_pend[i];
    for (int i = 0; i < NCH; i++) begin
      m_tick[i] = 0;
      if (!en[i] || sync || m_half[i] == 0) begin
        m_cnt[i] = 0;
        m_clk[i] = 0;
        if (m_pend[i]) begin m_half[i] = m_pval[i]; m_pend[i] = 0; end
      end else if (m_cnt[i] + 1 == m_half[i]) begin
        m_cnt[i]  = 0;
        m_clk[i]  = !m_clk[i];
        m_tick[i] = 1;
        if (m_pend[i]) begin m_half[i] = m_pval[i]; m_pend[i] = 0; end
      end else begin
        m_cnt[i] = m_cnt[i] + 1;
      end
      if (acc[i]) begin m_pval[i] = int'(cfg_half); m_pend[i] = 1; end
    end
    exp_q.push_back({m_clk[1], m_clk[0], m_tick[1], m_tick[0]});
    @(posedge clk);
    #2;
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic write_cfg(input int ch, input int h);
    cfg_valid = 1'b1;
    cfg_chan  = 1'(ch);
    cfg_half  = CW'(h);
    cyc();
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; cfg_valid = 1'b0; cfg_chan = '0; cfg_half = '0;
    en = '0; sync = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    tests_run++;
    if (clk_out !== 2'b00 || tick !== 2'b00) begin
      failures++;
      $display("FAIL reset_outputs clk_out=%b tick=%b exp 00/00", clk_out, tick);
    end
    reset_n = 1'b1;
    #1;
    tests_run++;
    if (cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=1", cfg_ready);
    end
  endtask

  task automatic test_default_period();
    int t0 = 0, t1 = 0;
    en = 2'b11;
    repeat (12) begin
      cyc();
      if (tick[0]) t0++;
      if (tick[1]) t1++;
    end
    tests_run++;
    if (t0 != 4 || t1 != 4) begin
      failures++;
      $display("FAIL default_ticks got ch0=%0d ch1=%0d exp 4/4", t0, t1);
    end
    tests_run++;
    if (clk_out !== 2'b00) begin
      failures++;
      $display("FAIL default_phase clk_out=%b exp=00", clk_out);
    end
  endtask

  task automatic test_cfg_update();
    int last = -1, gap = -1, t0 = 0;
    cyc();
    cfg_valid = 1'b1; cfg_chan = 1'b1; cfg_half = CW'(5);
    #1;
    tests_run++;
    if (cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL cfg_first_ready got=%b exp=1", cfg_ready);
    end
    cyc();
    cfg_half = CW'(7);
    #1;
    tests_run++;
    if (cfg_ready !== 1'b0) begin
      failures++;
      $display("FAIL cfg_stall_ready got=%b exp=0", cfg_ready);
    end
    cyc();
    cfg_valid = 1'b0;
    for (int n = 0; n < 30; n++) begin
      cyc();
      if (tick[0]) t0++;
      if (tick[1]) begin
        if (last >= 0) gap = n - last;
        last = n;
      end
    end
    tests_run++;
    if (gap != 5) begin
      failures++;
      $display("FAIL cfg_new_period ch1 gap got=%0d exp=5", gap);
    end
    tests_run++;
    if (t0 != 10) begin
      failures++;
      $display("FAIL cfg_other_chan ch0 ticks got=%0d exp=10", t0);
    end
  endtask

  task automatic test_park();
    int t0 = 0, last = -1, gap = -1;
    write_cfg(0, 0);
    run(5);
    repeat (10) begin
      cyc();
      if (tick[0] || clk_out[0]) t0++;
    end
    tests_run++;
    if (t0 != 0) begin
      failures++;
      $display("FAIL park_quiet active cycles got=%0d exp=0", t0);
    end
    write_cfg(0, 2);
    for (int n = 0; n < 12; n++) begin
      cyc();
      if (tick[0]) begin
        if (last >= 0) gap = n - last;
        last = n;
      end
    end
    tests_run++;
    if (gap != 2) begin
      failures++;
      $display("FAIL park_wake ch0 gap got=%0d exp=2", gap);
    end
  endtask

  task automatic test_enable();
    int n = 0;
    bit seen = 0;
    write_cfg(0, 3);
    run(8);
    cyc();
    en = 2'b01;
    cyc();
    tests_run++;
    if (clk_out[1] !== 1'b0 || tick[1] !== 1'b0) begin
      failures++;
      $display("FAIL disable ch1 clk_out=%b tick=%b exp 0/0", clk_out[1], tick[1]);
    end
    run(3);
    en = 2'b11;
    while (!seen && n < 20) begin
      cyc();
      n++;
      if (tick[1]) seen = 1;
    end
    tests_run++;
    if (!seen || n != 5) begin
      failures++;
      $display("FAIL reenable first tick after got=%0d cycles exp=5", n);
    end
  endtask

  task automatic test_sync();
    bit hit = 0;
    write_cfg(1, 4);
    run(12);
    for (int n = 0; n < 10 && !hit; n++) begin
      #1;
      if (m_cnt[0] + 1 == m_half[0]) begin
        sync = 1'b1;
        cyc();
        sync = 1'b0;
        hit = 1;
      end else begin
        cyc();
      end
    end
    tests_run++;
    if (!hit || tick !== 2'b00 || clk_out !== 2'b00) begin
      failures++;
      $display("FAIL sync_clear hit=%0d tick=%b clk_out=%b exp 00/00", hit, tick, clk_out);
    end
    run(12);
    tests_run++;
    if (tick !== 2'b11) begin
      failures++;
      $display("FAIL sync_align tick=%b exp=11", tick);
    end
  endtask

  task automatic test_reset_mid();
    int t1 = 0;
    write_cfg(1, 20);
    cyc();
    #4;
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (clk_out !== 2'b00 || tick !== 2'b00) begin
      failures++;
      $display("FAIL async_reset clk_out=%b tick=%b exp 00/00", clk_out, tick);
    end
    model_reset();
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    cfg_chan = 1'b1;
    #1;
    tests_run++;
    if (cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_drop_pend ready got=%b exp=1", cfg_ready);
    end
    repeat (12) begin
      cyc();
      if (tick[1]) t1++;
    end
    tests_run++;
    if (t1 != 4) begin
      failures++;
      $display("FAIL reset_def_half ch1 ticks got=%0d exp=4", t1);
    end
  endtask

  initial begin
    test_reset();
    test_default_period();
    test_cfg_update();
    test_park();
    test_enable();
    test_sync();
    test_reset_mid();
    @(posedge clk);
    #3;
    tests_run++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule

// File: doc/clock_divider_multi.md
# clock_divider_multi

Parametrised successor to the single-output fixed divider. It provides NUM_CH independent divided-clock channels with a terminal count that can be reprogrammed at run time. Each channel has its own enable, a glitch-free divisor update, a one-cycle tick strobe and a common phase-sync restart. It sits next to the system clock and feeds slow timebases such as display refresh and debounce sampling, replacing hard-coded 250_000 counters.

## Interface
- NUM_CH, 4: number of channels, at least 1
- CNT_W, 18: counter and half-period width
- DEF_HALF, 250000: half-period loaded at reset for every channel; must fit CNT_W
- CH_W, $clog2(NUM_CH) (minimum 1): channel index width

Ports:
- clk  in  1  system clock, all logic on posedge
- reset_n  in  1  asynchronous, active-low reset
- cfg_valid  in  1  configuration write request
- cfg_ready  out  1  write accepted this cycle when high together with cfg_valid
- cfg_chan  in  CH_W  target channel
- cfg_half  in  CNT_W  new half-period H in cycles
- en  in  NUM_CH  per-channel run enable
- sync  in  1  restart all enabled channels in phase
- clk_out  out  NUM_CH  divided clock, period 2·H cycles, 50 % duty
- tick  out  NUM_CH  one-cycle strobe on every clk_out toggle

## Operation
- Per-channel state: cnt[CNT_W], half[CNT_W] (active value), pend_val[CNT_W], pend flag, clk_out, tick.
- Reset (reset_n low): cnt=0, half=DEF_HALF, pend=0, clk_out=0, tick=0. cfg_ready reads 1 from the first cycle after release.
- Running channel (en=1, half≥1): cnt counts up by 1 each cycle. When cnt==half−1 the channel hits terminal count (TC): cnt←0, clk_out toggles, tick=1 for that one cycle. There is no 250_001-style off-by-one; the period is exactly 2·half.
- half==0: channel is parked. cnt=0, clk_out=0, tick never fires. A later load wakes it.
- en=0: on the next edge cnt←0, clk_out←0 and tick=0, and the channel stays there. On an en rising edge the channel counts from 0, so the first toggle comes half cycles later.
- Config handshake: cfg_ready = !pend[cfg_chan] (combinational on cfg_chan). An accept (valid & ready) latches pend_val and sets pend.
- Pending apply: half←pend_val and pend←0 on the channel's next TC, so the current half-period completes unchanged and there is no glitch. If the channel is disabled or parked, the apply happens on the cycle after the accept.
- cfg_chan ≥ NUM_CH: the request is accepted (ready=1) and dropped.
- sync=1: every enabled channel gets cnt←0, clk_out←0 and tick=0, and any pending value is applied immediately. sync takes priority over TC in the same cycle. Disabled channels ignore sync.

## Timing
- All outputs are registered. tick and the clk_out toggle change on the same edge.
- Accept in the same cycle as that channel's TC: the TC uses the old half. The new value applies at the following TC.
- Latency from config to a new period is at most 2·old_half cycles. A second write to the same channel stalls (cfg_ready=0) until the first one has applied.
- Counter compare is CNT_W-wide unsigned and cnt never exceeds half−1. If half is lowered mid-count, it only takes effect at TC, so cnt cannot overrun.
- reset_n asserted mid-count: outputs clear immediately (asynchronous) and pending writes are lost.

## Structure
- Package clkdiv_pkg holds DEF_CNT_W, DEF_HALF and a per-channel state struct (cnt, half, pend_val, pend).
- Sub-module clock_divider_chan contains one channel's counter, pending register and TC logic. The top level generates NUM_CH instances, decodes cfg_chan and muxes cfg_ready.

## Test plan
- Reset, NUM_CH=2, DEF_HALF=3, en=2'b11 → clk_out toggles every 3 cycles (period 6), tick high one cycle per toggle, both channels in phase.
- Write ch1 half=5 mid-period → ch1 finishes its current 3-cycle half, then toggles every 5. A second write before apply sees cfg_ready=0. ch0 is unaffected.
- Write half=0 to ch0 → ch0 clk_out held 0 and no ticks. Write half=2 → toggling resumes with period 4 starting the cycle after the accept.
- en[1] deasserted mid-count → clk_out[1]=0 and tick[1]=0 next cycle. Re-enable → first toggle exactly half cycles later.
- ch0 half=3 and ch1 half=4 drifting, pulse sync on a cycle where ch0 would TC → both counters zero, no tick that cycle, both clk_out low, aligned from then on.
- reset_n pulsed low mid-period with a write pending → outputs 0 asynchronously, half=DEF_HALF, pending write discarded.
